// File: rtl/regfile_hilo.sv
// 32 x 32-bit general-purpose register file with two combinational read ports,
// write-through bypass, and separate HI/LO registers. Reset is synchronous and active-high.
module regfile_hilo (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        hi_we,
  input  logic [31:0] hi_i,
  output logic [31:0] hi_o,
  input  logic        lo_we,
  input  logic [31:0] lo_i,
  output logic [31:0] lo_o
);

  localparam int unsigned reg_bus_w  = 32;
  localparam int unsigned reg_addr_w = 5;
  localparam int unsigned reg_num    = 1 << reg_addr_w;

  logic [reg_bus_w-1:0] regs_q [reg_num];
  logic [reg_bus_w-1:0] regs_d [reg_num];
  logic [reg_bus_w-1:0] hi_q, hi_d;
  logic [reg_bus_w-1:0] lo_q, lo_d;

  // Register $0 is pinned to zero, so a write addressed to it never lands.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hi_we) hi_d = hi_i;
    if (lo_we) lo_d = lo_i;
  end

  // NOTE: the whole array is reset because every GPR must read zero one cycle
  // after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      regs_q <= regs_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  // The enable is tested for an explicit 1, so an unknown enable reads zero.
  function automatic logic [reg_bus_w-1:0] read_port(
    input logic                  rst_i,
    input logic                  re_i,
    input logic [reg_addr_w-1:0] raddr_i,
    input logic                  we_i,
    input logic [reg_addr_w-1:0] waddr_i,
    input logic [reg_bus_w-1:0]  wdata_i,
    input logic [reg_bus_w-1:0]  stored_i
  );
    logic [reg_bus_w-1:0] val;
    val = '0;
    if (!rst_i && (re_i == 1'b1) && (raddr_i != '0)) begin
      if (we_i && (raddr_i == waddr_i)) val = wdata_i;
      else                              val = stored_i;
    end
    return val;
  endfunction

  always_comb begin
    rdata1 = read_port(rst, re1, raddr1, we, waddr, wdata, regs_q[raddr1]);
    rdata2 = read_port(rst, re2, raddr2, we, waddr, wdata, regs_q[raddr2]);
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_regfile_hilo.sv
// Directed bench for regfile_hilo: inputs change on the falling edge, outputs are
// sampled 1 ns later, and expected values are written by hand.
module tb_regfile_hilo;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        hi_we, lo_we;
  logic [31:0] hi_i, lo_i, hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  regfile_hilo dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .hi_we  (hi_we),
    .hi_i   (hi_i),
    .hi_o   (hi_o),
    .lo_we  (lo_we),
    .lo_i   (lo_i),
    .lo_o   (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Pass one rising edge and return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b0; raddr2 = 5'd0;
    hi_we = 1'b1; hi_i = 32'h0000_1234; lo_we = 1'b1; lo_i = 32'h0000_4321;
    #1;
    check("rd1_during_rst", rdata1, 32'h0);
    tick();
    check("hi_after_rst_edge", hi_o, 32'h0);
    tick();

    // Release reset; the write held during reset must be gone.
    rst = 1'b0; we = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    #1;
    check("r5_after_rst", rdata1, 32'h0);
    check("hi_after_rst", hi_o, 32'h0);
    check("lo_after_rst", lo_o, 32'h0);

    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; re1 = 1'b0;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    #1;
    check("r7_port1", rdata1, 32'h12345678);
    check("r7_port2", rdata2, 32'h12345678);
    re1 = 1'b0;
    #1;
    check("r7_re1_off", rdata1, 32'h0);
    re1 = 1'bx;
    #1;
    check("r7_re1_x", rdata1, 32'h0);

    // Writes to $0 are discarded, both in the bypass and in storage.
    @(negedge clk);
    re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    #1;
    check("r0_bypass_p1", rdata1, 32'h0);
    check("r0_bypass_p2", rdata2, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("r0_after_p1", rdata1, 32'h0);
    check("r0_after_p2", rdata2, 32'h0);

    @(negedge clk);
    we = 1'b1; waddr = 5'd3; wdata = 32'h11111111;
    tick();
    we = 1'b0; raddr1 = 5'd3; raddr2 = 5'd3;
    #1;
    check("r3_initial", rdata1, 32'h11111111);
    @(negedge clk);
    we = 1'b1; wdata = 32'h22222222;
    #1;
    check("bypass_p1", rdata1, 32'h22222222);
    check("bypass_p2", rdata2, 32'h22222222);
    tick();
    we = 1'b0;
    #1;
    check("r3_after_p1", rdata1, 32'h22222222);
    check("r3_after_p2", rdata2, 32'h22222222);
    raddr2 = 5'd7;
    #1;
    check("r7_kept", rdata2, 32'h12345678);

    // HI and LO are registered only; no bypass.
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b0; hi_i = 32'hAAAA0000; lo_i = 32'h00005555;
    #1;
    check("hi_before_edge", hi_o, 32'h0);
    tick();
    hi_we = 1'b0;
    #1;
    check("hi_after_edge", hi_o, 32'hAAAA0000);
    check("lo_unchanged", lo_o, 32'h0);
    @(negedge clk);
    lo_we = 1'b1;
    #1;
    check("lo_before_edge", lo_o, 32'h0);
    tick();
    lo_we = 1'b0;
    #1;
    check("lo_after_edge", lo_o, 32'h00005555);
    check("hi_held", hi_o, 32'hAAAA0000);

    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; hi_i = 32'h0BAD_F00D; lo_i = 32'hC0FF_EE00;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    #1;
    check("hi_both", hi_o, 32'h0BAD_F00D);
    check("lo_both", lo_o, 32'hC0FF_EE00);

    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'h00009999;
    tick();
    we = 1'b0; raddr1 = 5'd9;
    #1;
    check("r9_written", rdata1, 32'h00009999);

    // Reset arriving together with pending writes wipes everything.
    @(negedge clk);
    rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h00000ABC;
    hi_we = 1'b1; hi_i = 32'hFFFF_FFFF;
    #1;
    check("rd_during_midrst", rdata1, 32'h0);
    tick();
    rst = 1'b0; we = 1'b0; hi_we = 1'b0; raddr2 = 5'd3;
    #1;
    check("r9_midrst", rdata1, 32'h0);
    check("r3_midrst", rdata2, 32'h0);
    check("hi_midrst", hi_o, 32'h0);
    check("lo_midrst", lo_o, 32'h0);
    raddr2 = 5'd7;
    #1;
    check("r7_midrst", rdata2, 32'h0);

    @(negedge clk);
    we = 1'b1; waddr = 5'd31; wdata = 32'h8000_0001; raddr1 = 5'd31;
    tick();
    we = 1'b0;
    #1;
    check("r31_first_write", rdata1, 32'h8000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_hilo.md
REGFILE_HILO -- requirements
Module: regfile_hilo

Interface
REQ-001 The block SHALL have no parameters; widths SHALL come from defines.v: `RegBus = 32 bits, `RegAddrBus = 5 bits.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  synchronous reset, active high (`RstEnable = 1).
REQ-005 we  input  1  GPR write enable, driven from wb_reg_we.
REQ-006 waddr  input  5  GPR write address, driven from wb_waddr.
REQ-007 wdata  input  32  GPR write data, driven from wb_data.
REQ-008 re1 / re2  input  1 each  read-port enable, ports 1 and 2.
REQ-009 raddr1 / raddr2  input  5 each  read-port address.
REQ-010 rdata1 / rdata2  output  32 each  read-port data (combinational).
REQ-011 hi_we / lo_we  input  1 each  HI / LO write enable, driven from wb_hi_we / wb_lo_we.
REQ-012 hi_i / lo_i  input  32 each  HI / LO write data, driven from wb_hi / wb_lo.
REQ-013 hi_o / lo_o  output  32 each  current registered HI / LO value.

Function
REQ-014 Storage SHALL be 32 x 32-bit GPRs (regs[0..31]) plus the 32-bit HI register and the 32-bit LO register.
REQ-015 GPR write: at the posedge, if rst=0, we=1 and waddr!=0, then regs[waddr] <= wdata; otherwise no GPR changes.
REQ-016 A write to $0 SHALL be discarded; regs[0] SHALL always read as 0.
REQ-017 HI write: at the posedge, if rst=0 and hi_we=1, then HI <= hi_i.
REQ-018 LO write: at the posedge, if rst=0 and lo_we=1, then LO <= lo_i; HI and LO writes SHALL be independent and may occur in the same cycle.
REQ-019 Each read port SHALL be purely combinational with zero latency, evaluated in this priority order:
- rst=1 -> 0
- re=0 -> 0
- raddr=0 -> 0
- we=1 and raddr==waddr -> wdata (write-through bypass)
- otherwise -> regs[raddr]
REQ-020 The bypass SHALL apply to each port independently; both ports reading the address being written SHALL both return wdata in that cycle.
REQ-021 hi_o / lo_o SHALL be the registered HI / LO values with no bypass; a write becomes visible on the cycle after the write edge.
REQ-022 A GPR write SHALL take 1 cycle: the value is in regs after the edge and is readable the same cycle through the bypass.
REQ-023 Unknown or X on re1/re2 SHALL NOT corrupt stored state; reads SHALL never modify state.

Reset
REQ-024 With rst=1 at a posedge, all 31 writable GPRs, HI and LO SHALL clear to 0 in that single cycle; any write request in that cycle SHALL be ignored.
REQ-025 While rst=1, rdata1/rdata2 SHALL be 0 regardless of the other inputs; hi_o/lo_o SHALL read 0 from the first edge after rst is asserted.
REQ-026 When rst is asserted mid-operation (a write pending in the same cycle), the write SHALL be lost and the state SHALL be fully zeroed.
REQ-027 The first write SHALL take effect on the first posedge with rst=0.

Verification
REQ-028 Reset: hold rst=1 for 2 cycles with we=1, waddr=5, wdata=0xDEADBEEF -> after deassertion, reading r5 returns 0x00000000 and hi_o=lo_o=0.
REQ-029 Write then read: write r7=0x12345678; next cycle re1=1, raddr1=7 -> rdata1=0x12345678; with re1=0 -> rdata1=0.
REQ-030 Zero register: we=1, waddr=0, wdata=0xFFFFFFFF -> in the same cycle and later, raddr1=0 and raddr2=0 both return 0.
REQ-031 Bypass: r3 holds 0x11111111; in a single cycle, we=1, waddr=3, wdata=0x22222222, raddr1=raddr2=3 -> both ports return 0x22222222 in that cycle and keep returning it afterwards.
REQ-032 HI/LO: hi_we=1, lo_we=0, hi_i=0xAAAA0000, lo_i=0x5555 -> hi_o=0xAAAA0000 only after the edge, lo_o unchanged; then lo_we=1 -> lo_o=0x00005555 on the following cycle.
REQ-033 Reset mid-write: rst=1 together with we=1, waddr=9 and hi_we=1 -> r9, HI and LO are all 0 after the edge.
